ahb_slave_if: RTL and testbench
===============================

# ahb_slave_if

AHB-Lite responder front-end of the AHB2APB bridge. It accepts AHB transfers from the bus master, registers address, control and write data across the AHB pipeline, and decodes the peripheral select. It presents one transfer at a time to the downstream APB controller over a valid/done handshake, inserting wait states until completion. It returns read data and an OKAY or two-cycle ERROR response.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum cycles in ST_XFER waiting for `xfer_done` before ERROR is forced; legal range 2–255.
- `NUM_SEL`, 3: number of peripheral selects; fixed by the address map.

Ports:
- `Hclk` in 1: sole clock; all state changes on its rising edge.
- `Hresetn` in 1: reset, asynchronous, active-low.
- `Hwrite` in 1: 1 = write, 0 = read; sampled in the address phase.
- `Hreadyin` in 1: bus-wide HREADY; an address phase is taken only when high.
- `Htrans` in 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `Haddr` in 32: transfer address.
- `Hwdata` in 32: write data, valid in the data phase.
- `Hreadyout` out 1: 0 = wait state.
- `Hresp` out 2: OKAY=00, ERROR=01.
- `Hrdata` out 32: read data, registered.
- `xfer_valid` out 1: transfer request to the APB side.
- `xfer_write` out 1: registered `Hwrite`.
- `xfer_addr` out 32: registered `Haddr`.
- `xfer_wdata` out 32: registered `Hwdata`.
- `xfer_sel` out NUM_SEL: one-hot peripheral select.
- `xfer_done` in 1: APB side has completed the request.
- `xfer_err` in 1: qualifies `xfer_done` as failed.
- `xfer_rdata` in 32: read data, valid with `xfer_done`.

## Operation
- Address map:
  - 0x8000_0000–0x83FF_FFFF → sel[0]
  - 0x8400_0000–0x87FF_FFFF → sel[1]
  - 0x8800_0000–0x8BFF_FFFF → sel[2]
  - any other address is unmapped.
- Address phase accepted when `Hreadyin`=1, `Htrans`∈{NONSEQ, SEQ} and `Hreadyout`=1 (states IDLE, DONE, ERR2).
  - On acceptance, register addr, write and sel.
  - IDLE/BUSY transfers get an OKAY zero-wait response and change no state.
- FSM states:
  - ST_IDLE: `Hreadyout`=1, OKAY.
    - Mapped accept → ST_DATA.
    - Unmapped accept → ST_ERR1.
  - ST_DATA: `Hreadyout`=0. Registers `Hwdata` into `xfer_wdata` on writes; holds it on reads. → ST_XFER.
  - ST_XFER: `xfer_valid`=1, `Hreadyout`=0. Timeout counter increments each cycle.
    - `xfer_done`=1 and `xfer_err`=0 → ST_DONE; read latches `xfer_rdata` into `Hrdata`.
    - `xfer_done`=1 and `xfer_err`=1 → ST_ERR1.
    - Counter reaches TIMEOUT−1 without done → ST_ERR1 and `xfer_valid` drops.
  - ST_DONE: `Hreadyout`=1, OKAY. Accepts the next address phase with the same rules as ST_IDLE; otherwise → ST_IDLE.
  - ST_ERR1: `Hresp`=ERROR, `Hreadyout`=0. → ST_ERR2.
  - ST_ERR2: `Hresp`=ERROR, `Hreadyout`=1. Accepts a new address phase as in ST_IDLE; the master may cancel with IDLE.
- `xfer_done` outside ST_XFER is ignored.
- `xfer_valid`, `xfer_addr`, `xfer_write`, `xfer_sel` and `xfer_wdata` are stable for the whole of ST_XFER.
- Reset (asynchronous, any state):
  - State → ST_IDLE.
  - `Hreadyout`=1, `Hresp`=00, `Hrdata`=0.
  - `xfer_valid`=0, `xfer_write`=0, `xfer_addr`=0, `xfer_wdata`=0, `xfer_sel`=0.
  - Timeout counter cleared.
  - An in-flight transfer is dropped with no response.

## Timing
- Address phase sampled at edge E0. ST_DATA occupies E0–E1; ST_XFER begins at E1.
- If `xfer_done` is seen at edge E1+k (k≥1), `Hreadyout` is high in the cycle after that edge.
  - Minimum wait states per transfer: 2.
  - `Hrdata` is valid in that same cycle.
- ERROR path: exactly 1 wait cycle, then 1 ready cycle, with `Hresp`=ERROR in both.
- Unmapped address: ERR1 in the cycle after E0.
- Back-to-back transfers: the next address phase is accepted in the DONE or ERR2 cycle, so there are no idle bubbles between transfers.
- Timeout: at most TIMEOUT cycles in ST_XFER; the counter is cleared on entry to ST_XFER.

## Structure
- Package `ahb_apb_pkg` holds:
  - HTRANS and HRESP encodings
  - the address-map base/limit constants
  - the FSM state enum
  - NUM_SEL.
- Sub-module `ahb_addr_decode`: combinational `Haddr` → one-hot sel plus a `mapped` flag. It is shared later with the APB controller.

## Test plan
- Reset mid-XFER: assert `Hresetn`=0 during ST_XFER → all outputs at reset values the same cycle; `Hreadyout`=1 after release.
- Single write: NONSEQ write to 0x8000_0001, `Hwdata`=0xA3, `xfer_done` on the first XFER cycle → `xfer_sel`=001, `xfer_wdata`=0xA3, `Hreadyout` low for exactly 2 cycles, OKAY.
- Single read: NONSEQ read to 0x8000_00A2, `xfer_rdata`=0xDEAD_BEEF, done after 3 cycles → `Hrdata`=0xDEAD_BEEF with `Hreadyout`=1, 4 wait states total.
- Unmapped access: NONSEQ to 0x9000_0000 → `xfer_valid` never asserted; `Hresp`=01 for 2 cycles with `Hreadyout`=0 then 1.
- Error and timeout:
  - `xfer_done` with `xfer_err`=1 → two-cycle ERROR.
  - `xfer_done` never asserted (TIMEOUT=16) → ERROR after 16 XFER cycles and `xfer_valid` deasserts.
- Back-to-back and ignore cases:
  - Write to 0x8400_0010 immediately followed in the DONE cycle by a read to 0x8800_0020 → `xfer_sel`=010 then 100, with no idle cycle between.
  - BUSY and `Hreadyin`=0 phases are ignored.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// Shared encodings, address map and FSM states for the AHB2APB bridge.
package ahb_apb_pkg;

   localparam int unsigned NUM_SEL = 3;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01
   } hresp_e;

   // Each peripheral owns a 64 MiB window.
   localparam logic [31:0] MAP_BASE [NUM_SEL] = '{32'h8000_0000, 32'h8400_0000, 32'h8800_0000};
   localparam logic [31:0] MAP_LIMIT[NUM_SEL] = '{32'h83FF_FFFF, 32'h87FF_FFFF, 32'h8BFF_FFFF};

   typedef enum logic [2:0] {
      StIdle,
      StData,
      StXfer,
      StDone,
      StErr1,
      StErr2
   } state_e;

   function automatic logic htrans_active(input logic [1:0] trans);
      return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational address decoder: one-hot peripheral select plus a mapped flag.
module ahb_addr_decode
   import ahb_apb_pkg::*;
(
   input  logic [31:0]        addr,
   output logic [NUM_SEL-1:0] sel,
   output logic               mapped
);

   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_SEL; i++) begin
         if (addr >= MAP_BASE[i] && addr <= MAP_LIMIT[i]) begin
            sel[i] = 1'b1;
         end
      end
      mapped = |sel;
   end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-Lite responder front-end: registers one transfer, hands it to the APB side over
// valid/done, and returns read data with an OKAY or two-cycle ERROR response.
module ahb_slave_if #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned NUM_SEL = 3
) (
   input  logic               Hclk,
   input  logic               Hresetn,
   input  logic               Hwrite,
   input  logic               Hreadyin,
   input  logic [1:0]         Htrans,
   input  logic [31:0]        Haddr,
   input  logic [31:0]        Hwdata,
   output logic               Hreadyout,
   output logic [1:0]         Hresp,
   output logic [31:0]        Hrdata,
   output logic               xfer_valid,
   output logic               xfer_write,
   output logic [31:0]        xfer_addr,
   output logic [31:0]        xfer_wdata,
   output logic [NUM_SEL-1:0] xfer_sel,
   input  logic               xfer_done,
   input  logic               xfer_err,
   input  logic [31:0]        xfer_rdata
);

   import ahb_apb_pkg::*;

   localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

   state_e             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [NUM_SEL-1:0] dec_sel;
   logic               dec_mapped;
   logic               accept;

   ahb_addr_decode u_decode (
      .addr   (Haddr),
      .sel    (dec_sel),
      .mapped (dec_mapped)
   );

   // Hreadyout is only high in IDLE, DONE and ERR2, so it gates acceptance by state.
   assign accept = Hreadyin && htrans_active(Htrans) && Hreadyout;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle, StDone, StErr2: begin
            if (accept) state_d = dec_mapped ? StData : StErr1;
            else        state_d = StIdle;
         end
         StData: begin
            state_d = StXfer;
            cnt_d   = '0;
         end
         StXfer: begin
            if (xfer_done)              state_d = xfer_err ? StErr1 : StDone;
            else if (cnt_q == CntLast)  state_d = StErr1;
            else                        cnt_d   = cnt_q + 8'd1;
         end
         StErr1:  state_d = StErr2;
         default: state_d = StIdle;
      endcase
   end

   // Bus-facing outputs are registered from the next state so they change with it.
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         Hreadyout  <= 1'b1;
         Hresp      <= HRESP_OKAY;
         Hrdata     <= '0;
         xfer_valid <= 1'b0;
         xfer_write <= 1'b0;
         xfer_addr  <= '0;
         xfer_wdata <= '0;
         xfer_sel   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         Hreadyout  <= state_d inside {StIdle, StDone, StErr2};
         Hresp      <= (state_d inside {StErr1, StErr2}) ? HRESP_ERROR : HRESP_OKAY;
         xfer_valid <= (state_d == StXfer);
         if (accept) begin
            xfer_addr  <= Haddr;
            xfer_write <= Hwrite;
            xfer_sel   <= dec_sel;
         end
         if (state_q == StData && xfer_write) begin
            xfer_wdata <= Hwdata;
         end
         if (state_q == StXfer && xfer_done && !xfer_err && !xfer_write) begin
            Hrdata <= xfer_rdata;
         end
      end
   end

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed bench for ahb_slave_if with queued expectations checked by a monitor.
module tb_ahb_slave_if;

   logic        Hclk = 1'b0;
   logic        Hresetn, Hwrite, Hreadyin;
   logic [1:0]  Htrans;
   logic [31:0] Haddr, Hwdata;
   logic        Hreadyout;
   logic [1:0]  Hresp;
   logic [31:0] Hrdata;
   logic        xfer_valid, xfer_write;
   logic [31:0] xfer_addr, xfer_wdata;
   logic [2:0]  xfer_sel;
   logic        xfer_done, xfer_err;
   logic [31:0] xfer_rdata;

   ahb_slave_if #(.TIMEOUT(16), .NUM_SEL(3)) dut (
      .Hclk       (Hclk),
      .Hresetn    (Hresetn),
      .Hwrite     (Hwrite),
      .Hreadyin   (Hreadyin),
      .Htrans     (Htrans),
      .Haddr      (Haddr),
      .Hwdata     (Hwdata),
      .Hreadyout  (Hreadyout),
      .Hresp      (Hresp),
      .Hrdata     (Hrdata),
      .xfer_valid (xfer_valid),
      .xfer_write (xfer_write),
      .xfer_addr  (xfer_addr),
      .xfer_wdata (xfer_wdata),
      .xfer_sel   (xfer_sel),
      .xfer_done  (xfer_done),
      .xfer_err   (xfer_err),
      .xfer_rdata (xfer_rdata)
   );

   always #5 Hclk = ~Hclk;

   typedef struct {
      logic        rd;
      logic [31:0] rdata;
      logic [1:0]  resp;
      int          waits;
   } rsp_t;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [2:0]  sel;
   } req_t;

   rsp_t rsp_q[$];
   req_t req_q[$];

   int errors = 0;
   int checks = 0;

   // APB responder knobs: done on the Nth XFER cycle (0 = never).
   int          apb_delay = 1;
   logic        apb_err   = 1'b0;
   logic [31:0] apb_rdata = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // APB responder
   initial begin
      int cnt;
      cnt = 0;
      xfer_done  = 1'b0;
      xfer_err   = 1'b0;
      xfer_rdata = '0;
      forever begin
         @(posedge Hclk);
         #1;
         if (xfer_valid) cnt++;
         else            cnt = 0;
         xfer_done  = xfer_valid && (apb_delay != 0) && (cnt == apb_delay);
         xfer_err   = apb_err;
         xfer_rdata = apb_rdata;
      end
   end

   // Monitor: compares APB requests on rising xfer_valid, responses when ready returns.
   initial begin
      int         waits;
      logic       valid_prev;
      logic [1:0] last_resp;
      rsp_t       r;
      req_t       q;
      waits      = 0;
      valid_prev = 1'b0;
      last_resp  = '0;
      forever begin
         @(negedge Hclk);
         if (!Hresetn) begin
            waits      = 0;
            valid_prev = 1'b0;
         end else begin
            if (xfer_valid && !valid_prev) begin
               if (req_q.size() == 0) begin
                  check("req_unexpected", 32'(xfer_valid), 32'd0);
               end else begin
                  q = req_q.pop_front();
                  check("req_addr", xfer_addr, q.addr);
                  check("req_write", 32'(xfer_write), 32'(q.wr));
                  check("req_sel", 32'(xfer_sel), 32'(q.sel));
                  if (q.wr) check("req_wdata", xfer_wdata, q.wdata);
               end
            end
            valid_prev = xfer_valid;
            if (!Hreadyout) begin
               waits++;
               last_resp = Hresp;
            end else if (waits > 0) begin
               if (rsp_q.size() == 0) begin
                  check("rsp_unexpected", 32'(waits), 32'd0);
               end else begin
                  r = rsp_q.pop_front();
                  check("rsp_waits", 32'(waits), 32'(r.waits));
                  check("rsp_hresp", 32'(Hresp), 32'(r.resp));
                  check("rsp_wait_hresp", 32'(last_resp), 32'(r.resp));
                  if (r.rd && r.resp == 2'b00) check("rsp_hrdata", Hrdata, r.rdata);
               end
               waits = 0;
            end
         end
      end
   end

   task automatic addr_phase(input logic [31:0] a, input logic w);
      Htrans   = 2'b10;
      Haddr    = a;
      Hwrite   = w;
      Hreadyin = 1'b1;
   endtask

   task automatic bus_idle();
      Htrans = 2'b00;
   endtask

   // Wait for a ready cycle, then step past the edge that ends it.
   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!Hreadyout && n < 100) begin
         @(posedge Hclk);
         #1;
         n++;
      end
      if (!Hreadyout) begin
         checks++;
         errors++;
         $display("FAIL %s: Hreadyout stuck at 0 after %0d cycles, expected 1", tag, n);
      end
      @(posedge Hclk);
      #1;
   endtask

   initial begin
      Hresetn  = 1'b0;
      Hwrite   = 1'b0;
      Hreadyin = 1'b1;
      Htrans   = 2'b00;
      Haddr    = '0;
      Hwdata   = '0;

      // Reset values
      #12;
      check("rst_hreadyout", 32'(Hreadyout), 32'd1);
      check("rst_hresp", 32'(Hresp), 32'd0);
      check("rst_hrdata", Hrdata, 32'd0);
      check("rst_xfer_valid", 32'(xfer_valid), 32'd0);
      check("rst_xfer_sel", 32'(xfer_sel), 32'd0);
      #10;
      Hresetn = 1'b1;
      @(posedge Hclk);
      #1;

      // Single write, done on first XFER cycle
      apb_delay = 1;
      apb_err   = 1'b0;
      req_q.push_back('{addr: 32'h8000_0001, wr: 1'b1, wdata: 32'h0000_00A3, sel: 3'b001});
      rsp_q.push_back('{rd: 1'b0, rdata: '0, resp: 2'b00, waits: 2});
      addr_phase(32'h8000_0001, 1'b1);
      wait_ready("wr_addr");
      Hwdata = 32'h0000_00A3;
      bus_idle();
      wait_ready("wr_data");

      // Single read, done on third XFER cycle
      apb_delay = 3;
      apb_rdata = 32'hDEAD_BEEF;
      req_q.push_back('{addr: 32'h8000_00A2, wr: 1'b0, wdata: '0, sel: 3'b001});
      rsp_q.push_back('{rd: 1'b1, rdata: 32'hDEAD_BEEF, resp: 2'b00, waits: 4});
      addr_phase(32'h8000_00A2, 1'b0);
      wait_ready("rd_addr");
      bus_idle();
      wait_ready("rd_data");

      // Reset while in XFER
      apb_delay = 0;
      addr_phase(32'h8000_0100, 1'b1);
      wait_ready("rst_addr");
      Hwdata = 32'h0000_0055;
      bus_idle();
      @(posedge Hclk);
      #1;
      check("mid_xfer_valid", 32'(xfer_valid), 32'd1);
      #2;
      Hresetn = 1'b0;
      #1;
      check("mid_rst_hreadyout", 32'(Hreadyout), 32'd1);
      check("mid_rst_hresp", 32'(Hresp), 32'd0);
      check("mid_rst_hrdata", Hrdata, 32'd0);
      check("mid_rst_xfer_valid", 32'(xfer_valid), 32'd0);
      check("mid_rst_xfer_addr", xfer_addr, 32'd0);
      check("mid_rst_xfer_wdata", xfer_wdata, 32'd0);
      check("mid_rst_xfer_write", 32'(xfer_write), 32'd0);
      check("mid_rst_xfer_sel", 32'(xfer_sel), 32'd0);
      #10;
      Hresetn = 1'b1;
      @(posedge Hclk);
      #1;
      check("post_rst_hreadyout", 32'(Hreadyout), 32'd1);

      // Unmapped address: no APB request, two-cycle ERROR
      rsp_q.push_back('{rd: 1'b0, rdata: '0, resp: 2'b01, waits: 1});
      addr_phase(32'h9000_0000, 1'b0);
      wait_ready("unmap_addr");
      bus_idle();
      wait_ready("unmap_data");

      // APB error on second XFER cycle
      apb_delay = 2;
      apb_err   = 1'b1;
      req_q.push_back('{addr: 32'h8400_0004, wr: 1'b1, wdata: 32'h0000_0077, sel: 3'b010});
      rsp_q.push_back('{rd: 1'b0, rdata: '0, resp: 2'b01, waits: 4});
      addr_phase(32'h8400_0004, 1'b1);
      wait_ready("err_addr");
      Hwdata = 32'h0000_0077;
      bus_idle();
      wait_ready("err_data");
      apb_err = 1'b0;

      // Timeout: DATA + 16 XFER + ERR1 wait cycles
      apb_delay = 0;
      req_q.push_back('{addr: 32'h8800_0008, wr: 1'b0, wdata: '0, sel: 3'b100});
      rsp_q.push_back('{rd: 1'b1, rdata: '0, resp: 2'b01, waits: 18});
      addr_phase(32'h8800_0008, 1'b0);
      wait_ready("to_addr");
      bus_idle();
      wait_ready("to_data");
      check("to_valid_dropped", 32'(xfer_valid), 32'd0);

      // Back-to-back: read address phase held until the write's DONE cycle
      apb_delay = 1;
      apb_rdata = 32'hCAFE_F00D;
      req_q.push_back('{addr: 32'h8400_0010, wr: 1'b1, wdata: 32'h1234_5678, sel: 3'b010});
      rsp_q.push_back('{rd: 1'b0, rdata: '0, resp: 2'b00, waits: 2});
      req_q.push_back('{addr: 32'h8800_0020, wr: 1'b0, wdata: '0, sel: 3'b100});
      rsp_q.push_back('{rd: 1'b1, rdata: 32'hCAFE_F00D, resp: 2'b00, waits: 2});
      addr_phase(32'h8400_0010, 1'b1);
      wait_ready("b2b_addr1");
      Hwdata = 32'h1234_5678;
      addr_phase(32'h8800_0020, 1'b0);
      wait_ready("b2b_addr2");
      check("b2b_no_bubble", 32'(Hreadyout), 32'd0);
      Hwdata = '0;
      bus_idle();
      wait_ready("b2b_data2");

      // BUSY and Hreadyin=0 phases are ignored
      Htrans = 2'b01;
      Haddr  = 32'h8000_0000;
      for (int i = 0; i < 2; i++) begin
         @(posedge Hclk);
         #1;
         check("busy_ignored", 32'(Hreadyout), 32'd1);
      end
      Htrans   = 2'b10;
      Hreadyin = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge Hclk);
         #1;
         check("noready_ignored", 32'(Hreadyout), 32'd1);
      end
      Hreadyin = 1'b1;
      bus_idle();
      @(posedge Hclk);
      #1;
      check("ignored_no_valid", 32'(xfer_valid), 32'd0);

      repeat (3) @(posedge Hclk);
      check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
      check("req_q_drained", 32'(req_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
